reg_bank: RTL

REG_BANK -- requirements
Module: reg_bank

---
 rtl/reg_bank_pkg.sv | 10 +
 rtl/reg_bank_sweep.sv | 57 +++++
 rtl/reg_bank.sv | 75 +++++++
 3 files changed

// File: rtl/reg_bank_pkg.sv
// Shared types and default sizes for the reg_bank register file.
package reg_bank_pkg;
  localparam int DEF_DATA_W = 10;
  localparam int DEF_DEPTH  = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    SWEEP = 1'b1
  } sweep_state_e;
endpackage

// File: rtl/reg_bank_sweep.sv
// Clear-sweep sequencer: walks every index once after CLR, one per cycle.
//   state | meaning
//   IDLE  | no sweep, waiting for CLR
//   SWEEP | clearing index cnt_q, BUSY high
module reg_bank_sweep
  import reg_bank_pkg::*;
#(
  parameter int DEPTH  = DEF_DEPTH,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              CLKb,
  input  logic              RST,
  input  logic              CLR,
  output logic              BUSY,
  output logic              clr_stb_o,
  output logic [ADDR_W-1:0] clr_idx_o
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

  sweep_state_e      state_q;
  logic              busy_q;
  logic [ADDR_W-1:0] cnt_q;

  // CLR is only looked at in IDLE, so a request during a sweep is ignored.
  always_ff @(posedge CLKb) begin
    if (RST) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (CLR) begin
            state_q <= SWEEP;
            busy_q  <= 1'b1;
            cnt_q   <= '0;
          end
        end
        SWEEP: begin
          if (cnt_q == LAST_IDX) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + ADDR_W'(1);
          end
        end
      endcase
    end
  end

  assign BUSY      = busy_q;
  assign clr_stb_o = busy_q;
  assign clr_idx_o = cnt_q;

endmodule

// File: rtl/reg_bank.sv
// Two-read/one-write register bank with valid bits and a timed clear sweep.
// Define REG_BANK_BYPASS_EN to forward same-cycle write data to the read ports.
module reg_bank
  import reg_bank_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              CLKb,
  input  logic              RST,
  input  logic [DATA_W-1:0] D,
  input  logic              ENW,
  input  logic [ADDR_W-1:0] WRA,
  input  logic              ENR0,
  input  logic              ENR1,
  input  logic [ADDR_W-1:0] RDA0,
  input  logic [ADDR_W-1:0] RDA1,
  input  logic              CLR,
  output logic [DATA_W-1:0] Q0,
  output logic [DATA_W-1:0] Q1,
  output logic              VLD0,
  output logic              VLD1,
  output logic              BUSY
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DEPTH-1:0]  vld_q;
  logic              clr_stb;
  logic [ADDR_W-1:0] clr_idx;
  logic              wr_en;
  logic              byp0;
  logic              byp1;

  reg_bank_sweep #(
    .DEPTH (DEPTH),
    .ADDR_W(ADDR_W)
  ) u_sweep (
    .CLKb     (CLKb),
    .RST      (RST),
    .CLR      (CLR),
    .BUSY     (BUSY),
    .clr_stb_o(clr_stb),
    .clr_idx_o(clr_idx)
  );

  assign wr_en = ENW & ~BUSY;

  always_ff @(posedge CLKb) begin
    if (RST) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      vld_q <= '0;
    end else if (clr_stb) begin
      mem_q[clr_idx] <= '0;
      vld_q[clr_idx] <= 1'b0;
    end else if (wr_en) begin
      mem_q[WRA] <= D;
      vld_q[WRA] <= 1'b1;
    end
  end

`ifdef REG_BANK_BYPASS_EN
  assign byp0 = wr_en & (RDA0 == WRA);
  assign byp1 = wr_en & (RDA1 == WRA);
`else
  assign byp0 = 1'b0;
  assign byp1 = 1'b0;
`endif

  assign Q0   = !ENR0 ? '0 : (byp0 ? D : mem_q[RDA0]);
  assign Q1   = !ENR1 ? '0 : (byp1 ? D : mem_q[RDA1]);
  assign VLD0 = ENR0 & (byp0 | vld_q[RDA0]);
  assign VLD1 = ENR1 & (byp1 | vld_q[RDA1]);

endmodule
